pipe_pc_unit: RTL and testbench
===============================

// Module: pipe_pc_unit
// PURPOSE
//  IF-stage program counter with on-chip next-PC selection; successor to the single-source PC register.
//  - Next-PC sources: sequential increment, branch/jump redirect, exception trap vector.
//  - Optional return-address stack (RAS) that predicts return targets.
//  - Stall (wpcir=0) freezes PC; exceptions override stall. Drives instruction memory address and IF/ID flush.
// PARAMETERS
//  PC_W        32            PC width in bits
//  INC         4             sequential increment (bytes per instruction)
//  RESET_PC    32'hFFFFFFFC  PC value during and after reset (first fetch after reset = RESET_PC+INC)
//  TRAP_VEC    32'h00000008  PC loaded on exception
//  RAS_DEPTH   4             RAS entries (power of 2, >=2); used only with PIPE_PC_RAS_EN
// PORTS
//  clock       in   1     rising-edge clock
//  reset       in   1     synchronous, active-high reset
//  wpcir       in   1     1 = PC may advance; 0 = stall (hold PC)
//  br_taken    in   1     ID-stage branch/jump resolved taken
//  br_target   in   PC_W  redirect target, valid with br_taken
//  exc_req     in   1     exception/interrupt, take trap vector
//  call_push   in   1     ID has a call (jal); push link_addr onto RAS
//  link_addr   in   PC_W  return address to push
//  ret_pop     in   1     ID has a return (jr $31); predict from RAS
//  pc          out  PC_W  current fetch address
//  pc_plus     out  PC_W  pc + INC (combinational, mod 2^PC_W)
//  redirect    out  1     registered: PC was loaded from a non-sequential source last edge
//  ras_hit     out  1     registered: last accepted ret_pop used a RAS entry
// BEHAVIOUR
//  - Reset (reset=1 at posedge): pc<=RESET_PC, redirect<=0, ras_hit<=0, RAS count<=0, top ptr<=0.
//    Reset wins over all other inputs. pc also initialises to RESET_PC.
//  - Per-edge priority (reset=0):
//    1. exc_req=1: pc<=TRAP_VEC, redirect<=1, RAS flushed (count<=0). Applies even if wpcir=0.
//    2. wpcir=0: pc, RAS, redirect, ras_hit all hold; call_push/ret_pop/br_taken ignored.
//    3. br_taken=1: pc<=br_target, redirect<=1.
//    4. ret_pop=1 and RAS non-empty (RAS_EN only): pc<=RAS top, redirect<=1, ras_hit<=1.
//    5. otherwise: pc<=pc+INC, redirect<=0.
//  - ras_hit<=0 on every accepted edge (wpcir=1, no exc) where case 4 is not taken.
//  - Latency: one edge from input to pc; no combinational path from inputs to pc.
//  - Arithmetic: pc+INC wraps modulo 2^PC_W (all-ones region + INC -> low addresses); no overflow flag.
//  - RAS (circular buffer, count 0..RAS_DEPTH), operations only on accepted edges without exc_req:
//    - push only: write link_addr at top+1, top++, count=min(count+1,RAS_DEPTH); full overwrites oldest.
//    - pop only, count>0: target=top entry, top--, count--. Pop on empty: no change, falls to case 5.
//    - push+pop same edge: target=old top; top entry replaced by link_addr; top/count unchanged
//      (count 0: entry written, count<=1, no prediction).
//    - Pop is performed even when br_taken overrides the prediction (stack stays aligned with program).
//    - Pointer wraps modulo RAS_DEPTH.
// CONFIGURATION
//  PIPE_PC_RAS_EN defined: RAS built as above.
//  PIPE_PC_RAS_EN undefined: no RAS storage; call_push, link_addr, ret_pop ignored;
//    ras_hit tied 0; priority case 4 never taken.
// TESTING
//  1. reset=1 two cycles then wpcir=1 -> pc: FFFFFFFC, then 00000000, 00000004, 00000008.
//  2. pc=00000010, wpcir=0 for 3 cycles -> pc holds 00000010; redirect=0; then resumes 00000014.
//  3. wpcir=0 & exc_req=1 -> next pc=00000008, redirect=1; same edge br_taken=1 -> trap wins.
//  4. br_taken=1, br_target=00000400 at pc=00000020 -> pc=00000400, redirect=1 one cycle, then 00000404.
//  5. (RAS_EN) push 100,200,300,400,500 (depth 4), then 5 pops
//     -> pc=500,400,300,200 with ras_hit=1; 5th pop is sequential, ras_hit=0.
//  6. (RAS_EN) push 0x40 then same-edge push 0x80 + pop -> pc=0x40; next pop -> pc=0x80; reset mid-stack -> count 0.

Source files
------------

// File: rtl/pipe_pc_if.sv
// pipe_pc_if: interface between the IF/ID control logic and the program counter unit.
//   Control side (master) drives the stall, branch, exception and RAS hints.
//   PC unit (slave) returns the fetch address, its increment and status flags.
//   wpcir      1 = PC may advance, 0 = stall
//   br_taken   branch/jump resolved taken in ID; br_target is its destination
//   exc_req    exception/interrupt request, forces the trap vector
//   call_push  call in ID; link_addr is pushed onto the return-address stack
//   ret_pop    return in ID; target predicted from the return-address stack
//   pc         current fetch address
//   pc_plus    pc + increment (combinational)
//   redirect   PC was loaded from a non-sequential source on the last edge
//   ras_hit    last accepted return used a stack entry
interface pipe_pc_if #(
  parameter int PC_W = 32
) ();
  logic            wpcir;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            exc_req;
  logic            call_push;
  logic [PC_W-1:0] link_addr;
  logic            ret_pop;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus;
  logic            redirect;
  logic            ras_hit;

  modport master (
    output wpcir, br_taken, br_target, exc_req, call_push, link_addr, ret_pop,
    input  pc, pc_plus, redirect, ras_hit
  );

  modport slave (
    input  wpcir, br_taken, br_target, exc_req, call_push, link_addr, ret_pop,
    output pc, pc_plus, redirect, ras_hit
  );
endinterface

// File: rtl/pipe_pc_unit.sv
// pipe_pc_unit: IF-stage program counter with next-PC selection.
//   Next-PC sources, highest priority first: trap vector (exc_req, even when
//   stalled), hold (wpcir=0), branch/jump target, return-address-stack
//   prediction, sequential increment. pc is purely registered.
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high; loads RESET_PC and clears the stack
//   bus        pipe_pc_if.slave (control inputs, pc/pc_plus/redirect/ras_hit)
// Configuration macro:
//   PIPE_PC_RAS_EN  defined   -> circular return-address stack of RAS_DEPTH entries
//                   undefined -> no stack; call/return hints ignored, ras_hit stays 0
module pipe_pc_unit #(
  parameter int              PC_W      = 32,
  parameter int              INC       = 4,
  parameter logic [PC_W-1:0] RESET_PC  = 'hFFFF_FFFC,
  parameter logic [PC_W-1:0] TRAP_VEC  = 'h0000_0008,
  parameter int              RAS_DEPTH = 4
) (
  input logic     clock,
  input logic     reset,
  pipe_pc_if.slave bus
);

  localparam logic [PC_W-1:0] INC_V = PC_W'(INC);

  // Sequential successor; the adder simply wraps past the top of the address space.
  function automatic logic [PC_W-1:0] wrap_inc(input logic [PC_W-1:0] a);
    return a + INC_V;
  endfunction

  logic [PC_W-1:0] pc_p0, pc_nx;
  logic            redirect_p0, redirect_nx;
  logic            ras_hit_p0, ras_hit_nx;
  logic            ras_take;   // stack popped with a valid prediction this edge
  logic [PC_W-1:0] ras_tgt;

`ifdef PIPE_PC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_p0, top_nx;
  logic [CNT_W-1:0] cnt_p0, cnt_nx;
  logic             wr_en;
  logic [PTR_W-1:0] wr_ptr;

  // Stack bookkeeping. A pop is performed on any accepted edge even when a
  // taken branch overrides its prediction, so the stack tracks the program.
  always_comb begin
    top_nx   = top_p0;
    cnt_nx   = cnt_p0;
    wr_en    = 1'b0;
    wr_ptr   = top_p0;
    ras_take = 1'b0;
    ras_tgt  = ras_mem[top_p0];
    if (bus.exc_req) begin
      cnt_nx = '0;
    end else if (bus.wpcir) begin
      if (bus.call_push && bus.ret_pop) begin
        // Return then call: the top entry is consumed and replaced in place.
        wr_en = 1'b1;
        if (cnt_p0 == '0) cnt_nx = CNT_W'(1);
        else              ras_take = 1'b1;
      end else if (bus.call_push) begin
        wr_en  = 1'b1;
        wr_ptr = top_p0 + PTR_W'(1);
        top_nx = top_p0 + PTR_W'(1);
        // When full the write lands on the oldest entry and count saturates.
        if (cnt_p0 != CNT_W'(RAS_DEPTH)) cnt_nx = cnt_p0 + CNT_W'(1);
      end else if (bus.ret_pop && (cnt_p0 != '0)) begin
        ras_take = 1'b1;
        top_nx   = top_p0 - PTR_W'(1);
        cnt_nx   = cnt_p0 - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      top_p0 <= '0;
      cnt_p0 <= '0;
    end else begin
      top_p0 <= top_nx;
      cnt_p0 <= cnt_nx;
    end
  end

  // Stack entries carry no reset; only the count decides what is valid.
  always_ff @(posedge clock) begin
    if (!reset && wr_en) ras_mem[wr_ptr] <= bus.link_addr;
  end
`else
  logic unused_ras_inputs;
  assign unused_ras_inputs = ^{bus.call_push, bus.ret_pop, bus.link_addr};
  assign ras_take = 1'b0;
  assign ras_tgt  = '0;
`endif

  // Next-PC selection
  always_comb begin
    pc_nx       = pc_p0;
    redirect_nx = redirect_p0;
    ras_hit_nx  = ras_hit_p0;
    if (bus.exc_req) begin
      pc_nx       = TRAP_VEC;
      redirect_nx = 1'b1;
    end else if (bus.wpcir) begin
      ras_hit_nx = 1'b0;
      if (bus.br_taken) begin
        pc_nx       = bus.br_target;
        redirect_nx = 1'b1;
      end else if (ras_take) begin
        pc_nx       = ras_tgt;
        redirect_nx = 1'b1;
        ras_hit_nx  = 1'b1;
      end else begin
        pc_nx       = wrap_inc(pc_p0);
        redirect_nx = 1'b0;
      end
    end
  end

  // PC register stage
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_p0       <= RESET_PC;
      redirect_p0 <= 1'b0;
      ras_hit_p0  <= 1'b0;
    end else begin
      pc_p0       <= pc_nx;
      redirect_p0 <= redirect_nx;
      ras_hit_p0  <= ras_hit_nx;
    end
  end

  assign bus.pc       = pc_p0;
  assign bus.pc_plus  = wrap_inc(pc_p0);
  assign bus.redirect = redirect_p0;
  assign bus.ras_hit  = ras_hit_p0;

endmodule

// File: tb/tb_pipe_pc_unit.sv
// tb_pipe_pc_unit: directed scenarios plus randomized traffic for pipe_pc_unit,
// checked against a queue-based reference model of the next-PC rules.
module tb_pipe_pc_unit;
  localparam int          D     = 4;
  localparam logic [31:0] RST_V = 32'hFFFF_FFFC;
  localparam logic [31:0] TRAP  = 32'h0000_0008;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pipe_pc_if #(.PC_W(32)) bus ();

  pipe_pc_unit #(
    .PC_W(32), .INC(4), .RESET_PC(RST_V), .TRAP_VEC(TRAP), .RAS_DEPTH(D)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_redir;
  logic        m_hit;
  logic [31:0] m_ras[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic wp, input logic br,
                            input logic [31:0] tgt, input logic exc, input logic push,
                            input logic [31:0] link, input logic pop);
    logic        pred;
    logic [31:0] ptgt;
    pred = 1'b0;
    ptgt = '0;
    if (rst) begin
      m_pc = RST_V; m_redir = 1'b0; m_hit = 1'b0; m_ras.delete();
    end else if (exc) begin
      m_pc = TRAP; m_redir = 1'b1; m_ras.delete();
    end else if (wp) begin
`ifdef PIPE_PC_RAS_EN
      if (push && pop) begin
        if (m_ras.size() == 0) m_ras.push_back(link);
        else begin
          pred = 1'b1;
          ptgt = m_ras[$];
          m_ras[m_ras.size()-1] = link;
        end
      end else if (push) begin
        m_ras.push_back(link);
        if (m_ras.size() > D) void'(m_ras.pop_front());
      end else if (pop && m_ras.size() > 0) begin
        pred = 1'b1;
        ptgt = m_ras.pop_back();
      end
`endif
      m_hit = 1'b0;
      if (br)        begin m_pc = tgt;  m_redir = 1'b1; end
      else if (pred) begin m_pc = ptgt; m_redir = 1'b1; m_hit = 1'b1; end
      else           begin m_pc = m_pc + 32'd4; m_redir = 1'b0; end
    end
  endtask

  // Drive one edge's inputs, let the edge happen, compare shortly after it.
  task automatic step(input string tag, input logic rst, input logic wp, input logic br,
                      input logic [31:0] tgt, input logic exc, input logic push,
                      input logic [31:0] link, input logic pop);
    reset         = rst;
    bus.wpcir     = wp;
    bus.br_taken  = br;
    bus.br_target = tgt;
    bus.exc_req   = exc;
    bus.call_push = push;
    bus.link_addr = link;
    bus.ret_pop   = pop;
    @(posedge clock);
    model_edge(rst, wp, br, tgt, exc, push, link, pop);
    #1;
    check_val({tag, ".pc"},       bus.pc,                 m_pc);
    check_val({tag, ".pc_plus"},  bus.pc_plus,            m_pc + 32'd4);
    check_val({tag, ".redirect"}, {31'd0, bus.redirect},  {31'd0, m_redir});
    check_val({tag, ".ras_hit"},  {31'd0, bus.ras_hit},   {31'd0, m_hit});
  endtask

  task automatic seq(input string tag);
    step(tag, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic push_c(input logic [31:0] a);
    step("push", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, a, 1'b0);
  endtask

  task automatic pop_c(input logic [31:0] exp_pc, input logic exp_hit);
    step("pop", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    check_val("pop.abs_pc",  bus.pc,               exp_pc);
    check_val("pop.abs_hit", {31'd0, bus.ras_hit}, {31'd0, exp_hit});
  endtask

  initial begin
    reset = 1'b1;
    bus.wpcir = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0; bus.exc_req = 1'b0;
    bus.call_push = 1'b0; bus.link_addr = '0; bus.ret_pop = 1'b0;

    // Reset for two cycles, then sequential fetch from address 0
    step("rst0", 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    step("rst1", 1'b1, 1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 32'd0, 1'b0);
    check_val("rst.abs_pc", bus.pc, 32'hFFFF_FFFC);
    seq("seq0"); check_val("seq0.abs", bus.pc, 32'h0);
    seq("seq1"); check_val("seq1.abs", bus.pc, 32'h4);
    seq("seq2"); check_val("seq2.abs", bus.pc, 32'h8);
    seq("seq3"); seq("seq4");
    check_val("seq4.abs", bus.pc, 32'h10);

    // Stall holds, branch request ignored while stalled
    for (int i = 0; i < 3; i++)
      step("stall", 1'b0, 1'b0, i == 1, 32'h900, 1'b0, 1'b0, 32'd0, 1'b0);
    check_val("stall.abs", bus.pc, 32'h10);
    seq("resume"); check_val("resume.abs", bus.pc, 32'h14);

    // Exception overrides stall and a same-edge branch
    step("trap", 1'b0, 1'b0, 1'b1, 32'h500, 1'b1, 1'b0, 32'd0, 1'b0);
    check_val("trap.abs", bus.pc, 32'h8);
    check_val("trap.redir", {31'd0, bus.redirect}, 32'd1);

    // Branch redirect and the sequential fetch after it
    step("brto20", 1'b0, 1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 32'd0, 1'b0);
    step("br400", 1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 32'd0, 1'b0);
    check_val("br400.abs", bus.pc, 32'h400);
    seq("after_br"); check_val("after_br.abs", bus.pc, 32'h404);

    // Wrap at the top of the address space
    step("brtop", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 32'd0, 1'b0);
    seq("wrap0"); seq("wrap1");
    check_val("wrap.abs", bus.pc, 32'h0);

`ifdef PIPE_PC_RAS_EN
    // Overflowing push sequence then five pops
    push_c(32'h100); push_c(32'h200); push_c(32'h300); push_c(32'h400); push_c(32'h500);
    pop_c(32'h500, 1'b1); pop_c(32'h400, 1'b1); pop_c(32'h300, 1'b1); pop_c(32'h200, 1'b1);
    pop_c(32'h204, 1'b0);
    // Same-edge push and pop replaces the top entry
    push_c(32'h40);
    step("pushpop", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h80, 1'b1);
    check_val("pushpop.abs", bus.pc, 32'h40);
    pop_c(32'h80, 1'b1);
    // Reset mid-stack empties it
    push_c(32'h600); push_c(32'h700);
    step("rst_mid", 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    pop_c(32'h0, 1'b0);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step("rand",
           ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0),
           {$urandom_range(0, 32'h3FFF), 2'b00},
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) == 0),
           {$urandom_range(0, 32'h3FFF), 2'b00},
           ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
